btn_debouncer: RTL

Debounces a single raw mechanical push-button or switch input and produces a clean level plus single-cycle edge ticks. It sits directly upstream of the free-running display counter: `rise_tick` drives the counter's clear input, so one physical press restarts the count exactly once regardless of contact bounce. The block contains a 2-flop input synchronizer and a 4-state settle-timer FSM.

---
 rtl/btn_debouncer.sv | 109 ++++++++++
 1 files changed

// File: rtl/btn_debouncer.sv
// btn_debouncer: debounces one raw push-button/switch input.
// A 2-flop synchronizer feeds a 4-state settle-timer FSM. The FSM drives a
// registered clean level and single-cycle rise/fall ticks.
module btn_debouncer #(
    parameter int DB_COUNT = 1_000_000,
    parameter int CW       = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);
    localparam logic [CW-1:0] CNT_INC  = CW'(1);

    logic          sync1, sync2, sw_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          level_n, rise_n, fall_n;

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    assign sw_s = sync2;

    // State, settle counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ZERO;
            cnt       <= '0;
            db_level  <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            db_level  <= level_n;
            rise_tick <= rise_n;
            fall_tick <= fall_n;
        end
    end

    // Next-state logic: any opposite sample in a WAIT state aborts the wait.
    // The counter holds its value outside the WAIT states and stops at
    // CNT_LAST, so it never wraps.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_n = WAIT1;
                    cnt_n   = '0;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_n = ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_n = ONE;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_INC;
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_n = WAIT0;
                    cnt_n   = '0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_n = ONE;
                end else if (cnt == CNT_LAST) begin
                    state_n = ZERO;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_INC;
                end
            end
            default: state_n = ZERO;
        endcase
        // The level is registered from the next state, so it changes on the
        // same edge as its tick.
        level_n = (state_n == ONE) || (state_n == WAIT0);
    end

endmodule
